uart_frame_parser: RTL
======================

Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART top-level receive path and drains its RX FIFO (r_data / rd_uart / rx_empty).
- Parses a byte framing protocol: SOF, LEN, LEN payload bytes, CHK.
- Streams payload bytes to a downstream consumer over a valid/ready interface.
- Reports per-frame good/error status, and resynchronises on SOF after any error or inter-byte timeout.

Parameters:
- DBIT, 8: byte width; must match the UART DBIT.
- SOF_BYTE, 8'hA5: start-of-frame marker.
- MAX_LEN, 64: maximum legal LEN value, range 1..255.
- TIMEOUT_CYCLES, 100000: clk cycles a partial frame may wait with the FIFO empty before it is aborted.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- r_data  in  DBIT  RX FIFO head byte; first-word-fall-through, valid whenever rx_empty=0
- rx_empty  in  1  RX FIFO empty
- rd_uart  out  1  pop the RX FIFO head this cycle
- m_data  out  DBIT  payload byte
- m_valid  out  1  m_data valid
- m_ready  in  1  consumer accepts m_data when m_valid and m_ready are both high
- m_last  out  1  qualifies m_data as the final payload byte of the frame
- frame_done  out  1  one-cycle pulse; frame checksum matched
- frame_err  out  1  one-cycle pulse; frame aborted
- err_code  out  2  valid with frame_err: 0=checksum, 1=length, 2=timeout
- frame_cnt  out  16  count of good frames; wraps at 65535->0

Behaviour:
- Reset (asynchronous, active-high):
  - state=HUNT; all counters cleared.
  - rd_uart=0, m_valid=0, m_last=0, m_data=0, frame_done=0, frame_err=0, err_code=0, frame_cnt=0.
- rd_uart is combinational:
  - PAYLOAD state: rd_uart = ~rx_empty & (~m_valid | m_ready).
  - All other states: rd_uart = ~rx_empty.
  - Never asserted while reset is high.
- Every popped byte is consumed in the same cycle it is popped.
- State machine, all decisions made on the popped byte:
  - HUNT: byte==SOF_BYTE -> LEN; any other byte is discarded and state stays HUNT.
  - LEN:
    - byte==0 -> CHK.
    - byte>MAX_LEN -> frame_err (code 1), then HUNT.
    - otherwise load len_cnt=byte -> PAYLOAD.
    - The accumulator is initialised to the LEN byte: chk_acc = byte.
  - PAYLOAD:
    - On each pop: m_data<=byte, m_valid<=1, chk_acc ^= byte, len_cnt decrements.
    - m_last<=1 when len_cnt==1; on that pop go to CHK.
  - CHK:
    - byte==chk_acc -> frame_done pulse and frame_cnt increments.
    - mismatch -> frame_err (code 0).
    - Either way, go to HUNT.
- Output register:
  - A byte popped in cycle N appears on m_data/m_valid in cycle N+1.
  - m_valid clears after the handshake unless a new byte loads in the same cycle.
  - m_data/m_last hold stable while m_valid=1 and m_ready=0.
- frame_done/frame_err pulse in the cycle after the CHK (or bad LEN) pop.
  - They may coincide with a still-pending m_last byte. This is legal; the consumer must handle it.
- SOF_BYTE seen inside LEN/PAYLOAD/CHK is data, not a resync.
- Timeout:
  - gap_cnt runs only while state!=HUNT and rx_empty=1.
  - It clears on any pop and on entry to HUNT.
  - Consumer stall (m_ready=0 with rx_empty=0) does not advance it.
  - At gap_cnt==TIMEOUT_CYCLES-1: frame_err (code 2), state=HUNT.
  - An already-loaded m_valid byte is still delivered, with no m_last.
- Error-abort payload: bytes already streamed are not retracted; the frame_err pulse is the discard indication to the consumer.
- Back-to-back frames need no idle cycles. Sustained throughput is 1 byte/clk when m_ready=1.

Decomposition:
- Package uart_frame_pkg holds:
  - state enum {HUNT, LEN, PAYLOAD, CHK}
  - err_code constants ERR_CHK=2'd0, ERR_LEN=2'd1, ERR_TIMEOUT=2'd2
  - default SOF value
- One sub-module, uart_gap_timer: parameterised down-counter.
  - Inputs: clk, reset, run, clear.
  - Output: expired (one-cycle pulse).
  - Width is $clog2(TIMEOUT_CYCLES).
- Everything else stays in the parser.

Test Plan:
1. Good frame, m_ready=1: FIFO holds A5 03 11 22 33 03.
   - m_data = 11, 22, 33 on consecutive cycles, m_last with 33.
   - frame_done pulses once; frame_cnt=1; rd_uart never asserted while rx_empty=1.
2. Garbage before SOF: 00 FF A5 01 7E 7F.
   - 00 and FF are discarded; m_data=7E with m_last.
   - CHK 01^7E=7F matches, so frame_done.
3. Bad checksum and bad length:
   - A5 02 10 20 00 -> payload 10, 20 streamed, then frame_err with err_code=0.
   - A5 41 (with MAX_LEN=64) -> frame_err with err_code=1; the following A5 01 55 54 parses good.
4. Backpressure: frame of test 1 with m_ready low for 5 cycles at byte 22.
   - m_data holds 22 for the stall; rd_uart=0 during the stall.
   - No timeout while the FIFO is non-empty; final frame_done.
5. Timeout with TIMEOUT_CYCLES=20: feed A5 04 01, then FIFO empty for 25 cycles.
   - frame_err with err_code=2 after exactly 20 empty cycles.
   - A subsequent full frame parses good.
6. Reset mid-PAYLOAD: assert reset asynchronously between clock edges.
   - All outputs go to their reset values immediately; frame_cnt=0.
   - After release, a remaining payload byte equal to A5 is treated as SOF by HUNT.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared states, error codes and SOF default for the UART frame parser
package uart_frame_pkg;
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHK} state_t;
  localparam logic [1:0] ERR_CHK     = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: down-counter that pulses expired on the TIMEOUT_CYCLES-th consecutive run cycle
module uart_gap_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] TOP = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] r_cnt;
  assign expired = run & ~clear & (r_cnt == '0);
  always_ff @(posedge clk or posedge reset)
    if (reset)
      r_cnt <= TOP;
    else if (clear || expired)
      r_cnt <= TOP;
    else if (run)
      r_cnt <= r_cnt - 1'b1;
endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: drains the UART RX FIFO, parses SOF/LEN/payload/CHK frames and streams the payload
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int             DBIT           = 8,
  parameter logic [DBIT-1:0] SOF_BYTE      = DBIT'(SOF_DEFAULT),
  parameter int             MAX_LEN        = 64,
  parameter int             TIMEOUT_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DBIT-1:0] r_data,
  input  logic            rx_empty,
  output logic            rd_uart,
  output logic [DBIT-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic            frame_done,
  output logic            frame_err,
  output logic [1:0]      err_code,
  output logic [15:0]     frame_cnt
);
  localparam logic [DBIT-1:0] MAX_L = DBIT'(MAX_LEN);
  state_t          r_state, w_state_n;
  logic [DBIT-1:0] r_len, r_chk, r_m_data;
  logic            r_m_valid, r_m_last, r_done, r_err;
  logic [1:0]      r_code;
  logic [15:0]     r_cnt;
  logic            w_pop, w_expired, w_load, w_good, w_err_len, w_err_chk;
  // In PAYLOAD a pop needs a free output register (empty or draining this cycle)
  assign w_pop     = ~reset & ~rx_empty & ((r_state != PAYLOAD) | ~r_m_valid | m_ready);
  assign w_load    = w_pop & (r_state == PAYLOAD);
  assign w_good    = w_pop & (r_state == CHK) & (r_data == r_chk);
  assign w_err_chk = w_pop & (r_state == CHK) & (r_data != r_chk);
  assign w_err_len = w_pop & (r_state == LEN) & (r_data > MAX_L);
  uart_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
    .clk    (clk),
    .reset  (reset),
    .run    ((r_state != HUNT) & rx_empty),
    .clear  (w_pop | (r_state == HUNT)),
    .expired(w_expired)
  );
  always_comb begin
    w_state_n = r_state;
    if (w_expired)
      w_state_n = HUNT;
    else if (w_pop)
      case (r_state)
        HUNT:    w_state_n = (r_data == SOF_BYTE) ? LEN : HUNT;
        LEN:     w_state_n = (r_data == '0) ? CHK : (r_data > MAX_L) ? HUNT : PAYLOAD;
        PAYLOAD: w_state_n = (r_len == DBIT'(1)) ? CHK : PAYLOAD;
        default: w_state_n = HUNT;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= HUNT;
      r_len     <= '0;
      r_chk     <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_code    <= ERR_CHK;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_pop && r_state == LEN) begin
        r_len <= r_data;
        r_chk <= r_data;
      end else if (w_load) begin
        r_len <= r_len - 1'b1;
        r_chk <= r_chk ^ r_data;
      end
      if (w_load) begin
        r_m_data  <= r_data;
        r_m_valid <= 1'b1;
        r_m_last  <= (r_len == DBIT'(1));
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
      r_done <= w_good;
      r_err  <= w_expired | w_err_len | w_err_chk;
      r_code <= w_expired ? ERR_TIMEOUT : w_err_len ? ERR_LEN : w_err_chk ? ERR_CHK : r_code;
      r_cnt  <= r_cnt + {15'd0, w_good};
    end
  assign rd_uart    = w_pop;
  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign m_last     = r_m_last;
  assign frame_done = r_done;
  assign frame_err  = r_err;
  assign err_code   = r_code;
  assign frame_cnt  = r_cnt;
endmodule
